// File: rtl/key_expand.sv
// AES-128 key schedule: accepts a cipher key and produces round keys 0..ROUNDS,
// one per clock, holding all of them in registers until a new key or a reset.
module key_expand #(
    parameter int ROUNDS = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        key_valid,
    output logic                        key_ready,
    input  logic [127:0]                key,
    output logic                        busy,
    output logic                        keys_valid,
    output logic [128*(ROUNDS+1)-1:0]   rkeys
);

    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    // Forward S-box, entry 0 leftmost.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    // Round constants come from a table indexed by the round being generated.
    function automatic logic [7:0] rcon(input logic [CW-1:0] idx);
        case (idx)
            CW'(1):  return 8'h01;
            CW'(2):  return 8'h02;
            CW'(3):  return 8'h04;
            CW'(4):  return 8'h08;
            CW'(5):  return 8'h10;
            CW'(6):  return 8'h20;
            CW'(7):  return 8'h40;
            CW'(8):  return 8'h80;
            CW'(9):  return 8'h1b;
            CW'(10): return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt;
    logic [127:0]   rk [0:ROUNDS];
    logic [127:0]   prev;
    logic [127:0]   next_rk;
    logic           accept;

    assign key_ready  = (state_q != EXPAND);
    assign busy       = (state_q == EXPAND);
    assign keys_valid = (state_q == DONE);
    assign accept     = key_valid && key_ready;

    // Select the previous round key feeding the round function.
    always_comb begin
        // NOTE: default first so every path assigns prev; otherwise a latch is inferred.
        prev = '0;
        for (int i = 0; i < ROUNDS; i++) begin
            if (cnt == CW'(i + 1)) prev = rk[i];
        end
        next_rk = round_fn(prev, rcon(cnt));
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: accept from IDLE/DONE, finish after the last round.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (key_valid) state_d = EXPAND;
            EXPAND:     if (cnt == LAST) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Round counter and round-key registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            // NOTE: the key storage is reset on purpose; consumers see all-zero keys after reset.
            for (int i = 0; i <= ROUNDS; i++) rk[i] <= '0;
        end else if (accept) begin
            rk[0] <= key;
            cnt   <= CW'(1);
        end else if (state_q == EXPAND) begin
            rk[cnt] <= next_rk;
            cnt     <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    for (genvar g = 0; g <= ROUNDS; g++) begin : g_rkeys
        assign rkeys[128*g +: 128] = rk[g];
    end

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand: independent S-box/key-schedule/cipher model,
// scoreboard of expected round keys popped as the DUT writes each one.
module tb_key_expand;

    localparam int ROUNDS = 10;
    localparam int RW = 128 * (ROUNDS + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            key_valid = 1'b0;
    logic            key_ready;
    logic [127:0]    key = '0;
    logic            busy;
    logic            keys_valid;
    logic [RW-1:0]   rkeys;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int           idx;
        logic [127:0] val;
    } exp_t;

    exp_t          sb[$];
    logic [7:0]    sbox_t [256];
    logic [RW-1:0] exp_rkeys;

    key_expand #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rkeys      (rkeys)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (b != 0 && gf_mul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_t[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_step(input logic [127:0] p, input logic [7:0] rc);
        logic [31:0] w3, r, t, n0, n1, n2, n3;
        w3 = p[31:0];
        r  = {w3[23:0], w3[31:24]};
        t  = {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]} ^ {rc, 24'h0};
        n0 = p[127:96] ^ t;
        n1 = p[95:64] ^ n0;
        n2 = p[63:32] ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [RW-1:0] rks);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] st;
        st = pt ^ rks[127:0];
        for (int rnd = 1; rnd <= ROUNDS; rnd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_t[st[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r + 4*((c + r) % 4)];
            if (rnd != ROUNDS) begin
                for (int c = 0; c < 4; c++) begin
                    logic [7:0] a0, a1, a2, a3;
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int k = 0; k < 16; k++) st[127-8*k -: 8] = t[k];
            st = st ^ rks[128*rnd +: 128];
        end
        return st;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic apply_key(input logic [127:0] k);
        int waited = 0;
        @(negedge clk);
        while (!key_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!key_ready) begin
            checks++;
            $display("FAIL key_ready_timeout: key_ready=%b after %0d cycles, required 1", key_ready, waited);
        end
        key_valid = 1'b1;
        key       = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Accept a key and check each round key on the edge it is written.
    task automatic expand_and_check(input logic [127:0] k, input bit mid_pulse, input logic [127:0] other);
        logic [127:0] m = k;
        logic [7:0]   rc = 8'h01;
        exp_t         e;
        sb.delete();
        sb.push_back('{0, m});
        exp_rkeys[127:0] = m;
        for (int i = 1; i <= ROUNDS; i++) begin
            m = model_step(m, rc);
            rc = xt(rc);
            sb.push_back('{i, m});
            exp_rkeys[128*i +: 128] = m;
        end
        apply_key(k);
        checks++;
        if (busy !== 1'b1 || keys_valid !== 1'b0 || key_ready !== 1'b0)
            $display("FAIL accept_flags: busy=%b keys_valid=%b key_ready=%b, required 1 0 0", busy, keys_valid, key_ready);
        else passes++;
        e = sb.pop_front();
        checks++;
        if (rkeys[128*e.idx +: 128] !== e.val)
            $display("FAIL rk%0d: got %h expected %h", e.idx, rkeys[128*e.idx +: 128], e.val);
        else passes++;
        for (int i = 1; i <= ROUNDS; i++) begin
            if (mid_pulse && i == 3) begin
                key_valid = 1'b1;
                key       = other;
                checks++;
                if (key_ready !== 1'b0) $display("FAIL mid_key_ready: got %b expected 0", key_ready);
                else passes++;
            end
            @(posedge clk);
            #1;
            key_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (rkeys[128*e.idx +: 128] !== e.val)
                $display("FAIL rk%0d: got %h expected %h", e.idx, rkeys[128*e.idx +: 128], e.val);
            else passes++;
            checks++;
            if (keys_valid !== (i == ROUNDS))
                $display("FAIL keys_valid_edge%0d: got %b expected %b", i, keys_valid, (i == ROUNDS));
            else passes++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0)
            $display("FAIL reset_flags: key_ready=%b busy=%b keys_valid=%b, required 1 0 0", key_ready, busy, keys_valid);
        else passes++;
        checks++;
        if (rkeys !== '0) $display("FAIL reset_rkeys: got %h expected 0", rkeys);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fips();
        expand_and_check(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, '0);
        checks++;
        if (rkeys[128 +: 128] !== 128'ha0fafe1788542cb123a339392a6c7605)
            $display("FAIL fips_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", rkeys[128 +: 128]);
        else passes++;
        checks++;
        if (rkeys[1280 +: 128] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            $display("FAIL fips_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", rkeys[1280 +: 128]);
        else passes++;
    endtask

    task automatic test_cipher_and_hold();
        logic [127:0] ct;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (keys_valid !== 1'b1 || rkeys !== exp_rkeys)
            $display("FAIL hold_stable: keys_valid=%b rk10=%h expected 1 %h", keys_valid, rkeys[1280 +: 128], exp_rkeys[1280 +: 128]);
        else passes++;
        ct = aes_enc(128'h3243f6a8885a308d313198a2e0370734, rkeys);
        checks++;
        if (ct !== 128'h3925841d02dc09fbdc118597196a0b32)
            $display("FAIL cipher: got %h expected 3925841d02dc09fbdc118597196a0b32", ct);
        else passes++;
    endtask

    task automatic test_rekey_zero();
        expand_and_check('0, 1'b0, '0);
        checks++;
        if (rkeys[128 +: 128] !== 128'h62636363626363636263636362636363)
            $display("FAIL zero_rk1: got %h expected 62636363626363636263636362636363", rkeys[128 +: 128]);
        else passes++;
        checks++;
        if (rkeys[1280 +: 128] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e)
            $display("FAIL zero_rk10: got %h expected b4ef5bcb3e92e21123e951cf6f8f188e", rkeys[1280 +: 128]);
        else passes++;
    endtask

    task automatic test_mid_pulse();
        expand_and_check(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 128'hffeeddccbbaa99887766554433221100);
        checks++;
        if (rkeys[1280 +: 128] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || busy !== 1'b0)
            $display("FAIL mid_pulse_result: rk10=%h busy=%b expected d014f9a8c9ee2589e13f0cc8b6630ca6 0", rkeys[1280 +: 128], busy);
        else passes++;
    endtask

    task automatic test_reset_abort();
        apply_key(128'h000102030405060708090a0b0c0d0e0f);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0 || rkeys !== '0)
            $display("FAIL abort_reset: key_ready=%b busy=%b keys_valid=%b rk0=%h required 1 0 0 0", key_ready, busy, keys_valid, rkeys[127:0]);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        expand_and_check(128'h000102030405060708090a0b0c0d0e0f, 1'b0, '0);
    endtask

    task automatic test_reset_with_key();
        @(negedge clk);
        rst_n     = 1'b0;
        key_valid = 1'b1;
        key       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rkeys[127:0] !== 128'h0)
            $display("FAIL reset_vs_key: busy=%b rk0=%h required 0 0", busy, rkeys[127:0]);
        else passes++;
        @(negedge clk);
        key_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (key_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_vs_key_idle: key_ready=%b busy=%b required 1 0", key_ready, busy);
        else passes++;
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_cipher_and_hold();
        test_rekey_zero();
        test_mid_pulse();
        test_reset_abort();
        test_reset_with_key();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
